// File: rtl/cpu_rp_pkg.sv
// Shared types and helpers for the CPU result arbiter.
//   size_code_e : lane/size code carried in tag[8:5] of dcache/aux returns
//   src_e       : source index, also the round-robin order
//   wb_entry_t  : one queued writeback {dest, result}
//   lane_extract: byte/halfword selection + sign extension, returns {ok, data}
//   rr_next     : next source index, modulo 3
package cpu_rp_pkg;

  typedef enum logic [3:0] {
    SZ_B0 = 4'b0000,
    SZ_B1 = 4'b0001,
    SZ_B2 = 4'b0010,
    SZ_B3 = 4'b0011,
    SZ_H0 = 4'b0100,
    SZ_H1 = 4'b0110,
    SZ_W  = 4'b1000
  } size_code_e;

  typedef enum logic [1:0] {
    SRC_DCACHE = 2'd0,
    SRC_AUX    = 2'd1,
    SRC_DIV    = 2'd2
  } src_e;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] result;
  } wb_entry_t;

  // Undefined codes yield ok=0 and data=0; the entry is still written back.
  function automatic logic [32:0] lane_extract(input logic [3:0] code,
                                               input logic [31:0] word);
    logic [32:0] r;
    case (code)
      SZ_B0:   r = {1'b1, {24{word[7]}},  word[7:0]};
      SZ_B1:   r = {1'b1, {24{word[15]}}, word[15:8]};
      SZ_B2:   r = {1'b1, {24{word[23]}}, word[23:16]};
      SZ_B3:   r = {1'b1, {24{word[31]}}, word[31:24]};
      SZ_H0:   r = {1'b1, {16{word[15]}}, word[15:0]};
      SZ_H1:   r = {1'b1, {16{word[31]}}, word[31:16]};
      SZ_W:    r = {1'b1, word};
      default: r = {1'b0, 32'h0};
    endcase
    return r;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/cpu_result_arbiter_if.sv
// Bus bundle for the result arbiter: three source handshakes in, one
// writeback handshake out, plus the sticky bad-size flag.
//   slave  : arbiter view (sources in, readies/writeback out)
//   master : environment view (drives sources and wb_ready)
interface cpu_result_arbiter_if #(parameter int TAG_W = 9);
  logic             dcache_rvalid;
  logic [31:0]      dcache_rdata;
  logic [TAG_W-1:0] dcache_rtag;
  logic             dcache_rready;
  logic             aux_rvalid;
  logic [31:0]      aux_rdata;
  logic [TAG_W-1:0] aux_rtag;
  logic             aux_rready;
  logic             div_valid;
  logic [31:0]      div_result;
  logic [4:0]       div_dest_reg;
  logic             div_ready;
  logic             wb_valid;
  logic             wb_ready;
  logic [4:0]       wb_dest;
  logic [31:0]      wb_result;
  logic             err_bad_size;

  modport slave (
    input  dcache_rvalid, dcache_rdata, dcache_rtag,
    output dcache_rready,
    input  aux_rvalid, aux_rdata, aux_rtag,
    output aux_rready,
    input  div_valid, div_result, div_dest_reg,
    output div_ready,
    output wb_valid, wb_dest, wb_result,
    input  wb_ready,
    output err_bad_size
  );

  modport master (
    output dcache_rvalid, dcache_rdata, dcache_rtag,
    input  dcache_rready,
    output aux_rvalid, aux_rdata, aux_rtag,
    input  aux_rready,
    output div_valid, div_result, div_dest_reg,
    input  div_ready,
    input  wb_valid, wb_dest, wb_result,
    output wb_ready,
    input  err_bad_size
  );
endinterface

// File: rtl/result_fifo.sv
// Small per-source FIFO of writeback entries.
//   clock, reset_n : clock, async active-low reset (empties the queue)
//   push, din      : enqueue din (caller guarantees !full)
//   pop            : dequeue head (caller guarantees !empty)
//   full, empty    : occupancy flags
//   head           : oldest entry
module result_fifo
  import cpu_rp_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);
  localparam int PW = $clog2(QDEPTH);

  wb_entry_t      mem_q [QDEPTH];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [PW:0]    cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= din;
  end

  assign full  = (cnt_q == QDEPTH[PW:0]);
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rptr_q];
endmodule

// File: rtl/cpu_result_arbiter.sv
// Schedules dcache, aux-bus and divider results onto the single register
// writeback port. Each source has its own queue; a round-robin arbiter feeds
// a registered valid/ready output stage.
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : source handshakes, writeback handshake, err_bad_size
module cpu_result_arbiter
  import cpu_rp_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int TAG_W  = 9
) (
  input logic                  clock,
  input logic                  reset_n,
  cpu_result_arbiter_if.slave  bus
);
  logic        rdy_en_q;
  logic [2:0]  full, empty, push, pop;
  wb_entry_t   push_ent [3];
  wb_entry_t   head     [3];
  logic        dc_acc, aux_acc, div_acc;
  logic [32:0] dc_lane, aux_lane;

  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_result_q, wb_result_d;
  logic [1:0]  rr_q, rr_d;
  logic        err_q, err_d;

  // Holds all readies low during reset and releases them one edge later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rdy_en_q <= 1'b0;
    else          rdy_en_q <= 1'b1;
  end

  assign bus.dcache_rready = rdy_en_q & ~full[SRC_DCACHE];
  assign bus.aux_rready    = rdy_en_q & ~full[SRC_AUX];
  assign bus.div_ready     = rdy_en_q & ~full[SRC_DIV];

  assign dc_acc  = bus.dcache_rvalid & bus.dcache_rready;
  assign aux_acc = bus.aux_rvalid    & bus.aux_rready;
  assign div_acc = bus.div_valid     & bus.div_ready;

  assign dc_lane  = lane_extract(bus.dcache_rtag[8:5], bus.dcache_rdata);
  assign aux_lane = lane_extract(bus.aux_rtag[8:5],    bus.aux_rdata);

  assign push_ent[SRC_DCACHE] = '{dest: bus.dcache_rtag[4:0], result: dc_lane[31:0]};
  assign push_ent[SRC_AUX]    = '{dest: bus.aux_rtag[4:0],    result: aux_lane[31:0]};
  assign push_ent[SRC_DIV]    = '{dest: bus.div_dest_reg,     result: bus.div_result};

  // dest 0 completes the handshake but is never queued.
  assign push[SRC_DCACHE] = dc_acc  & (bus.dcache_rtag[4:0] != 5'd0);
  assign push[SRC_AUX]    = aux_acc & (bus.aux_rtag[4:0]    != 5'd0);
  assign push[SRC_DIV]    = div_acc & (bus.div_dest_reg     != 5'd0);

  for (genvar s = 0; s < 3; s++) begin : g_q
    result_fifo #(.QDEPTH(QDEPTH)) u_q (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push[s]),
      .pop     (pop[s]),
      .din     (push_ent[s]),
      .full    (full[s]),
      .empty   (empty[s]),
      .head    (head[s])
    );
  end

  // Round-robin search starting at rr_q.
  logic       found;
  logic [1:0] gnt, idx;
  always_comb begin
    found = 1'b0;
    gnt   = rr_q;
    idx   = rr_q;
    for (int k = 0; k < 3; k++) begin
      if (!found && !empty[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
      idx = rr_next(idx);
    end
  end

  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_dest_d   = wb_dest_q;
    wb_result_d = wb_result_q;
    rr_d        = rr_q;
    pop         = '0;
    if (!wb_valid_q || bus.wb_ready) begin
      if (found) begin
        wb_valid_d  = 1'b1;
        wb_dest_d   = head[gnt].dest;
        wb_result_d = head[gnt].result;
        pop[gnt]    = 1'b1;
        rr_d        = rr_next(gnt);
      end else begin
        wb_valid_d  = 1'b0;
      end
    end
  end

  assign err_d = err_q | (dc_acc & ~dc_lane[32]) | (aux_acc & ~aux_lane[32]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= 5'd0;
      wb_result_q <= 32'd0;
      rr_q        <= SRC_DCACHE;
      err_q       <= 1'b0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_dest_q   <= wb_dest_d;
      wb_result_q <= wb_result_d;
      rr_q        <= rr_d;
      err_q       <= err_d;
    end
  end

  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_dest      = wb_dest_q;
  assign bus.wb_result    = wb_result_q;
  assign bus.err_bad_size = err_q;
endmodule

// File: tb/tb_cpu_result_arbiter.sv
module tb_cpu_result_arbiter;
  logic clock = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  cpu_result_arbiter_if #(.TAG_W(9)) bus ();

  cpu_result_arbiter #(.QDEPTH(2), .TAG_W(9)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic idle_srcs;
    bus.dcache_rvalid = 1'b0;
    bus.aux_rvalid    = 1'b0;
    bus.div_valid     = 1'b0;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_srcs();
    bus.dcache_rdata = '0; bus.dcache_rtag = '0;
    bus.aux_rdata = '0;    bus.aux_rtag = '0;
    bus.div_result = '0;   bus.div_dest_reg = '0;
    bus.wb_ready = 1'b1;
    tick();
    // reset state
    chk("rst wb_valid", 32'(bus.wb_valid), 0);
    chk("rst wb_dest", 32'(bus.wb_dest), 0);
    chk("rst wb_result", bus.wb_result, 0);
    chk("rst err", 32'(bus.err_bad_size), 0);
    chk("rst readies", {29'd0, bus.dcache_rready, bus.aux_rready, bus.div_ready}, 0);
    reset_n = 1'b1;
    tick();
    chk("post-rst readies", {29'd0, bus.dcache_rready, bus.aux_rready, bus.div_ready}, 32'h7);

    // 1: byte1 sign extension, 2-cycle latency
    bus.dcache_rvalid = 1'b1; bus.dcache_rtag = {4'b0001, 5'd7}; bus.dcache_rdata = 32'h0000_8000;
    tick();
    idle_srcs();
    chk("t1 valid after push edge", 32'(bus.wb_valid), 0);
    tick();
    chk("t1 valid", 32'(bus.wb_valid), 1);
    chk("t1 dest", 32'(bus.wb_dest), 7);
    chk("t1 result", bus.wb_result, 32'hFFFF_FF80);
    tick();
    chk("t1 drained", 32'(bus.wb_valid), 0);

    // 2: three sources in one cycle, rr starting at dcache
    do_reset();
    bus.dcache_rvalid = 1'b1; bus.dcache_rtag = {4'b1000, 5'd1}; bus.dcache_rdata = 32'h1111_1111;
    bus.aux_rvalid = 1'b1;    bus.aux_rtag = {4'b1000, 5'd2};    bus.aux_rdata = 32'h2222_2222;
    bus.div_valid = 1'b1;     bus.div_dest_reg = 5'd3;           bus.div_result = 32'h3333_3333;
    tick();
    idle_srcs();
    tick();
    chk("t2 dest0", 32'(bus.wb_dest), 1);
    chk("t2 res0", bus.wb_result, 32'h1111_1111);
    tick();
    chk("t2 dest1", 32'(bus.wb_dest), 2);
    tick();
    chk("t2 dest2", 32'(bus.wb_dest), 3);
    chk("t2 res2", bus.wb_result, 32'h3333_3333);
    tick();
    chk("t2 empty", 32'(bus.wb_valid), 0);
    // pointer wrapped back to dcache: dcache wins over aux
    bus.dcache_rvalid = 1'b1; bus.dcache_rtag = {4'b1000, 5'd6}; bus.dcache_rdata = 32'h6;
    bus.aux_rvalid = 1'b1;    bus.aux_rtag = {4'b1000, 5'd5};    bus.aux_rdata = 32'h5;
    tick();
    idle_srcs();
    tick();
    chk("t2 rr dcache first", 32'(bus.wb_dest), 6);
    tick();
    chk("t2 rr aux second", 32'(bus.wb_dest), 5);
    tick();
    chk("t2 empty again", 32'(bus.wb_valid), 0);

    // 3: back-pressure; stall the output with a divider entry first
    bus.wb_ready = 1'b0;
    bus.div_valid = 1'b1; bus.div_dest_reg = 5'd9; bus.div_result = 32'h99;
    tick();
    idle_srcs();
    tick();
    chk("t3 stalled valid", 32'(bus.wb_valid), 1);
    chk("t3 stalled dest", 32'(bus.wb_dest), 9);
    bus.dcache_rvalid = 1'b1; bus.dcache_rtag = {4'b1000, 5'd10}; bus.dcache_rdata = 32'hA;
    tick();
    chk("t3 ready after 1", 32'(bus.dcache_rready), 1);
    bus.dcache_rtag = {4'b1000, 5'd11}; bus.dcache_rdata = 32'hB;
    tick();
    chk("t3 ready after 2", 32'(bus.dcache_rready), 0);
    bus.dcache_rtag = {4'b1000, 5'd12}; bus.dcache_rdata = 32'hC;
    tick();
    chk("t3 frozen dest", 32'(bus.wb_dest), 9);
    chk("t3 frozen result", bus.wb_result, 32'h99);
    tick();
    chk("t3 still frozen", 32'(bus.wb_dest), 9);
    chk("t3 still full", 32'(bus.dcache_rready), 0);
    bus.wb_ready = 1'b1;
    tick();
    chk("t3 drain 10", 32'(bus.wb_dest), 10);
    chk("t3 ready back", 32'(bus.dcache_rready), 1);
    tick();   // third push accepted on this edge
    idle_srcs();
    chk("t3 drain 11", 32'(bus.wb_dest), 11);
    chk("t3 res 11", bus.wb_result, 32'hB);
    tick();
    chk("t3 drain 12", 32'(bus.wb_dest), 12);
    chk("t3 res 12", bus.wb_result, 32'hC);
    tick();
    chk("t3 done", 32'(bus.wb_valid), 0);

    // 4: undefined size code 0101 via aux
    bus.aux_rvalid = 1'b1; bus.aux_rtag = {4'b0101, 5'd4}; bus.aux_rdata = 32'hFFFF_FFFF;
    tick();
    idle_srcs();
    chk("t4 err set", 32'(bus.err_bad_size), 1);
    tick();
    chk("t4 dest", 32'(bus.wb_dest), 4);
    chk("t4 result zero", bus.wb_result, 0);
    chk("t4 valid", 32'(bus.wb_valid), 1);
    // a good halfword afterwards must not clear the flag
    bus.aux_rvalid = 1'b1; bus.aux_rtag = {4'b0110, 5'd8}; bus.aux_rdata = 32'h8001_0000;
    tick();
    idle_srcs();
    tick();
    chk("t4 half1 result", bus.wb_result, 32'hFFFF_8001);
    chk("t4 err sticky", 32'(bus.err_bad_size), 1);
    tick();
    tick();
    chk("t4 err sticky later", 32'(bus.err_bad_size), 1);

    // 5: dest 0 is accepted and dropped
    chk("t5 ready", 32'(bus.dcache_rready), 1);
    bus.dcache_rvalid = 1'b1; bus.dcache_rtag = {4'b1000, 5'd0}; bus.dcache_rdata = 32'h1234;
    tick();
    idle_srcs();
    for (int i = 0; i < 4; i++) begin
      chk("t5 no valid", 32'(bus.wb_valid), 0);
      tick();
    end

    // 6: asynchronous reset mid-drain
    bus.dcache_rvalid = 1'b1; bus.dcache_rtag = {4'b1000, 5'd13}; bus.dcache_rdata = 32'hD;
    bus.aux_rvalid = 1'b1;    bus.aux_rtag = {4'b1000, 5'd14};    bus.aux_rdata = 32'hE;
    bus.div_valid = 1'b1;     bus.div_dest_reg = 5'd15;           bus.div_result = 32'hF;
    tick();
    idle_srcs();
    tick();
    chk("t6 draining", 32'(bus.wb_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6 async valid", 32'(bus.wb_valid), 0);
    chk("t6 async result", bus.wb_result, 0);
    chk("t6 async err", 32'(bus.err_bad_size), 0);
    chk("t6 async readies", {29'd0, bus.dcache_rready, bus.aux_rready, bus.div_ready}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6 readies", {29'd0, bus.dcache_rready, bus.aux_rready, bus.div_ready}, 32'h7);
    for (int i = 0; i < 4; i++) begin
      chk("t6 no stale", 32'(bus.wb_valid), 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
